// File: rtl/imem_loader.sv
// UART boot loader: parses A5/length/data/checksum frames and writes 32-bit words
// into the instruction RAM while holding the CPU in reset.
module imem_loader #(
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              imem_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] ONE_W     = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR
  } state_t;

  state_t          state_reg;
  logic [7:0]      len_lo_reg;
  logic [ADDR_W:0] n_words_reg;
  logic [23:0]     word_reg;
  logic [1:0]      byte_cnt_reg;
  logic [7:0]      csum_reg;
  logic [TW-1:0]   idle_cnt_reg;

  logic [15:0] len_full;
  logic        len_bad;

  assign len_full = {rx_byte, len_lo_reg};
  assign len_bad  = (len_full == 16'd0) || ({16'd0, len_full} > 32'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      len_lo_reg   <= 8'd0;
      n_words_reg  <= '0;
      word_reg     <= 24'd0;
      byte_cnt_reg <= 2'd0;
      csum_reg     <= 8'd0;
      idle_cnt_reg <= '0;
      imem_addr    <= '0;
      imem_data    <= 32'd0;
      imem_we      <= 1'b0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (rx_valid && rx_byte == 8'hA5) begin
            state_reg    <= ST_LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            csum_reg     <= 8'd0;
            byte_cnt_reg <= 2'd0;
            idle_cnt_reg <= '0;
            busy         <= 1'b1;
            cpu_rst      <= 1'b1;
          end
        end
        default: begin
          if (rx_valid) begin
            idle_cnt_reg <= '0;
            case (state_reg)
              ST_LEN_LO: begin
                len_lo_reg <= rx_byte;
                state_reg  <= ST_LEN_HI;
              end
              ST_LEN_HI: begin
                if (len_bad) begin
                  state_reg <= ST_ERROR;
                  busy      <= 1'b0;
                  error     <= 1'b1;
                end else begin
                  n_words_reg <= len_full[ADDR_W:0];
                  state_reg   <= ST_DATA;
                end
              end
              ST_DATA: begin
                csum_reg <= csum_reg ^ rx_byte;
                if (byte_cnt_reg == 2'd3) begin
                  // words_loaded doubles as the address of the word being written
                  imem_we      <= 1'b1;
                  imem_addr    <= words_loaded[ADDR_W-1:0];
                  imem_data    <= {rx_byte, word_reg};
                  words_loaded <= words_loaded + ONE_W;
                  byte_cnt_reg <= 2'd0;
                  if (words_loaded == n_words_reg - ONE_W)
                    state_reg <= ST_CSUM;
                end else begin
                  word_reg     <= {rx_byte, word_reg[23:8]};
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                end
              end
              ST_CSUM: begin
                busy <= 1'b0;
                if (rx_byte == csum_reg) begin
                  state_reg <= ST_DONE;
                  done      <= 1'b1;
                  cpu_rst   <= 1'b0;
                end else begin
                  state_reg <= ST_ERROR;
                  error     <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (idle_cnt_reg == IDLE_LAST) begin
            state_reg    <= ST_ERROR;
            busy         <= 1'b0;
            error        <= 1'b1;
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
